// File: rtl/ripple_pkg.sv
// Shared types and helpers for the ripple counter tap monitor.
// Contents:
//   state_e   - monitor FSM states (acquire baseline / track changes)
//   MaxW      - widest counter the delta helper supports
//   delta_mod - forward distance from old to new, modulo 2^width
package ripple_pkg;

  localparam int unsigned MaxW = 8;

  typedef enum logic [0:0] {
    StAcq,
    StTrack
  } state_e;

  function automatic logic [MaxW-1:0] delta_mod(input logic [MaxW-1:0] new_v,
                                                input logic [MaxW-1:0] old_v,
                                                input int unsigned     width);
    logic [MaxW-1:0] diff;
    logic [MaxW-1:0] mask;
    diff = new_v - old_v;
    mask = MaxW'((32'd1 << width) - 32'd1);
    return diff & mask;
  endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// Synchronizer plus run-length filter for the raw ripple counter output.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   cnt_in    in   raw counter value, asynchronous to clk
//   acc_val   out  most recently accepted (settled) value
//   acc_pulse out  1-cycle pulse each time a value newly settles
// A value settles once STABLE_CYC consecutive synchronized samples agree. The pulse
// fires once per settling; the parent decides whether it is a real change.
module ripple_sync_filter #(
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] acc_val,
  output logic             acc_pulse
);

  localparam int unsigned RunW = $clog2(STABLE_CYC + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYC);

  logic [CNT_W-1:0] sync_q [SYNC_STAGES];
  logic             start_q;
  logic [CNT_W-1:0] prev_q;
  logic [RunW-1:0]  run_q, run_d;
  logic [CNT_W-1:0] acc_val_q;
  logic             acc_pulse_q;
  logic [CNT_W-1:0] samp;
  logic             new_acc;

  assign samp = sync_q[SYNC_STAGES-1];

  always_comb begin
    run_d   = run_q;
    new_acc = 1'b0;
    if (start_q) begin
      if ((run_q != '0) && (samp == prev_q)) begin
        if (run_q != RunMax) begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = RunW'(1);
      end
      // Fire only on the cycle the run first reaches the threshold.
      new_acc = (run_d == RunMax) && ((run_q != RunMax) || (samp != prev_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      start_q     <= 1'b0;
      prev_q      <= '0;
      run_q       <= '0;
      acc_val_q   <= '0;
      acc_pulse_q <= 1'b0;
    end else begin
      sync_q[0] <= cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      // The first edge after release only refills the front stage; filtering starts next edge.
      start_q <= 1'b1;
      if (start_q) begin
        prev_q <= samp;
        run_q  <= run_d;
      end
      acc_pulse_q <= new_acc;
      if (new_acc) begin
        acc_val_q <= samp;
      end
    end
  end

  assign acc_val   = acc_val_q;
  assign acc_pulse = acc_pulse_q;

endmodule

// File: rtl/ripple_tap_monitor.sv
// Monitors a glitchy 2-bit ripple counter and presents a clean extended count.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cnt_in     in   raw ripple counter output
//   clr_err    in   clears err_sticky (set wins over clear)
//   count_out  out  {wrap count, accepted low value}
//   count_vld  out  high once a baseline has been acquired
//   step       out  pulse: accepted value is previous + 1
//   wrap       out  pulse: step from all-ones to zero
//   skip_err   out  pulse: accepted change was not +1
//   err_sticky out  latched skip_err
module ripple_tap_monitor
  import ripple_pkg::*;
#(
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned EXT_W       = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   clr_err,
  output logic [EXT_W+CNT_W-1:0] count_out,
  output logic                   count_vld,
  output logic                   step,
  output logic                   wrap,
  output logic                   skip_err,
  output logic                   err_sticky
);

  logic [CNT_W-1:0] acc_val;
  logic             acc_pulse;

  ripple_sync_filter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .acc_val  (acc_val),
    .acc_pulse(acc_pulse)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic             vld_q, vld_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             skip_q, skip_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] delta;

  assign delta = CNT_W'(delta_mod(MaxW'(acc_val), MaxW'(base_q), CNT_W));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ext_d   = ext_q;
    vld_d   = vld_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    skip_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      StAcq: begin
        if (acc_pulse) begin
          base_d  = acc_val;
          ext_d   = '0;
          vld_d   = 1'b1;
          state_d = StTrack;
        end
      end
      StTrack: begin
        // A re-settle on the current baseline (glitch that returned) is not a change.
        if (acc_pulse && (acc_val != base_q)) begin
          base_d = acc_val;
          if (delta == CNT_W'(1)) begin
            step_d = 1'b1;
            if (acc_val == '0) begin
              wrap_d = 1'b1;
              ext_d  = ext_q + 1'b1;
            end
          end else begin
            skip_d = 1'b1;
          end
        end
      end
      default: state_d = StAcq;
    endcase
    if (skip_d) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcq;
      base_q  <= '0;
      ext_q   <= '0;
      vld_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ext_q   <= ext_d;
      vld_q   <= vld_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  assign count_out  = {ext_q, base_q};
  assign count_vld  = vld_q;
  assign step       = step_q;
  assign wrap       = wrap_q;
  assign skip_err   = skip_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_ripple_tap_monitor.sv
// Bench for ripple_tap_monitor: directed scenarios, randomized holds/glitches/resets and a
// skewed ripple counter source, all scored every cycle against a sample-history model.
module tb_ripple_tap_monitor;

  localparam int Sync   = 2;
  localparam int Stable = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cnt_in;
  logic       clr_err;
  logic [7:0] count_out;
  logic       count_vld, step, wrap, skip_err, err_sticky;

  ripple_tap_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .clr_err   (clr_err),
    .count_out (count_out),
    .count_vld (count_vld),
    .step      (step),
    .wrap      (wrap),
    .skip_err  (skip_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int chk  = 0;
  int errs = 0;

  // Reference model: values seen at each edge since reset (index 0 is the cleared synchronizer).
  int hist[$];
  bit m_acq, m_vld, m_step, m_wrap, m_skip, m_err;
  int m_base, m_ext;

  bit ripple_phase = 0;
  int ripple_skips = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic tick();
    int t, v, d;
    bit acc;
    @(posedge clk);
    m_step = 0;
    m_wrap = 0;
    m_skip = 0;
    if (rst) begin
      hist.delete();
      hist.push_back(0);
      m_acq = 0; m_vld = 0; m_err = 0; m_base = 0; m_ext = 0;
    end else begin
      hist.push_back(int'(cnt_in));
      t   = hist.size() - 1;
      acc = 0;
      v   = 0;
      // Settled value visible on this edge: Stable equal samples ending Sync+1 edges ago,
      // preceded by a different sample (or none).
      if (t - Sync - Stable >= 0) begin
        v   = hist[t-Sync-1];
        acc = 1;
        for (int i = 0; i < Stable; i++) if (hist[t-Sync-1-i] != v) acc = 0;
        if (t - Sync - Stable - 1 >= 0 && hist[t-Sync-Stable-1] == v) acc = 0;
      end
      if (acc) begin
        if (!m_acq) begin
          m_acq = 1; m_vld = 1; m_base = v; m_ext = 0;
        end else if (v != m_base) begin
          d = (v - m_base + 4) % 4;
          if (d == 1) begin
            m_step = 1;
            if (v == 0) begin
              m_wrap = 1;
              m_ext  = (m_ext + 1) % 64;
            end
          end else begin
            m_skip = 1;
          end
          m_base = v;
        end
      end
      if (m_skip) m_err = 1;
      else if (clr_err) m_err = 0;
    end
    #1;
    check("count_out", count_out, 32'((m_ext << 2) | m_base));
    check("count_vld", count_vld, m_vld);
    check("step", step, m_step);
    check("wrap", wrap, m_wrap);
    check("skip_err", skip_err, m_skip);
    check("err_sticky", err_sticky, m_err);
    if (ripple_phase && skip_err) ripple_skips++;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  initial begin
    logic [1:0] c, nx;
    rst     = 1'b1;
    cnt_in  = 2'd0;
    clr_err = 1'b0;

    // Reset and acquisition
    repeat (2) tick();
    check("rst_count_out", count_out, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("acq_early_vld", count_vld, 0);
    tick();
    check("acq_vld", count_vld, 1);
    hold(2'd0, 4);

    // Steps
    hold(2'd1, 8);
    hold(2'd2, 8);
    hold(2'd3, 8);
    check("step_count3", count_out, 8'h03);

    // Wrap, then 63 more wraps bring ext back to zero
    hold(2'd0, 8);
    check("wrap_count4", count_out, 8'h04);
    for (int i = 0; i < 63; i++) begin
      hold(2'd1, 5); hold(2'd2, 5); hold(2'd3, 5); hold(2'd0, 5);
    end
    check("ext_rollover", count_out, 8'h00);

    // Skip error, then clear coinciding with the next skip
    hold(2'd1, 8);
    hold(2'd3, 8);
    check("skip_sticky", err_sticky, 1);
    check("skip_count", count_out, 8'h03);
    cnt_in = 2'd1;
    repeat (4) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins", err_sticky, 1);
    hold(2'd1, 3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err", err_sticky, 0);

    // Glitch rejection, then a 2-cycle hold that is accepted
    hold(2'd2, 1);
    hold(2'd1, 8);
    check("glitch_ignored", count_out, 8'h01);
    hold(2'd2, 2);
    hold(2'd3, 8);
    check("hold2_accepted", count_out, 8'h03);

    // Reach 0x0B, then reset mid-stream
    hold(2'd0, 6); hold(2'd1, 6); hold(2'd2, 6); hold(2'd3, 6);
    hold(2'd0, 6); hold(2'd1, 6); hold(2'd2, 6); hold(2'd3, 6);
    check("pre_rst_0b", count_out, 8'h0B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_zero", count_out, 8'h00);
    check("mid_rst_vld", count_vld, 0);
    hold(2'd3, 10);
    check("reacq_value", count_out, 8'h03);

    // Randomized holds, clears and occasional resets
    for (int i = 0; i < 300; i++) begin
      int n;
      cnt_in = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        clr_err = ($urandom_range(0, 7) == 0);
        rst     = ($urandom_range(0, 59) == 0);
        tick();
      end
    end
    clr_err = 1'b0;
    rst     = 1'b0;

    // Skewed ripple counter: bit0 toggles first, so 1->2 and 3->0 show a brief bad value
    hold(cnt_in, 8);
    ripple_phase = 1;
    c = cnt_in;
    for (int i = 0; i < 20; i++) begin
      nx = c + 2'd1;
      if (c[0]) begin
        cnt_in = {c[1], 1'b0};
        #2;
      end
      cnt_in = nx;
      repeat (8) tick();
      c = nx;
    end
    ripple_phase = 0;
    check("ripple_no_skip", ripple_skips, 0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
